// File: rtl/serial_pattern_gen.sv
// ---------------------------------------------------------------------------
// serial_pattern_gen
//
// Bit-serial pattern transmitter. A request (pattern, length, repeat count) is
// taken over a start/ready handshake. The pattern is then driven MSB-first
// (bit len-1 first) on o_x, one bit per clock, for the requested number of
// repetitions. An optional idle gap separates repetitions. A one-cycle o_done
// pulse follows the final bit. i_abort cancels a transfer without o_done.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous reset, active high
//   i_start    request valid (accepted when o_ready=1)
//   o_ready    high in IDLE only (decoded from state)
//   i_pattern  pattern bits, bit len-1 transmitted first
//   i_len      bits per repetition (clamped to MAX_LEN, 0 = no bits)
//   i_reps     repetition count (0 treated as 1)
//   i_abort    synchronous cancel of an active transfer
//   o_x        serial data (registered)
//   o_x_valid  o_x carries a pattern bit this cycle (registered)
//   o_busy     transfer in progress, SHIFT or GAP (registered)
//   o_done     one-cycle pulse after the final bit (registered)
// ---------------------------------------------------------------------------
module serial_pattern_gen #(
    parameter int MAX_LEN    = 8,
    parameter int LEN_W      = 4,
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_ready,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_len,
    input  logic [CNT_W-1:0]   i_reps,
    input  logic               i_abort,
    output logic               o_x,
    output logic               o_x_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ZERO  = '0;
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pat;        // pattern left-aligned: first bit at MSB
    logic [MAX_LEN-1:0] r_shift;      // remaining bits of the current repetition
    logic [LEN_W-1:0]   r_len_m1;     // effective length minus one, for reloads
    logic [LEN_W-1:0]   r_bit_cnt;    // bits still to send after the one on o_x
    logic [CNT_W-1:0]   r_reps_left;  // repetitions left, including the current one
    logic [GAP_W-1:0]   r_gap_cnt;    // gap cycles left after the current one

    logic [LEN_W-1:0]   w_len_eff;
    logic [LEN_W-1:0]   w_shamt;
    logic [MAX_LEN-1:0] w_aligned;
    logic [CNT_W-1:0]   w_reps_eff;

    assign w_len_eff  = (i_len > MAX_LEN_L) ? MAX_LEN_L : i_len;
    assign w_reps_eff = (i_reps == CNT_ZERO) ? CNT_ONE : i_reps;
    // Left-align the pattern so every repetition shifts out of the MSB
    // regardless of length; len=0 never reaches SHIFT, so its value is unused.
    assign w_shamt    = MAX_LEN_L - w_len_eff;
    assign w_aligned  = i_pattern << w_shamt;

    assign o_ready = (r_state == S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_shift     <= '0;
            r_len_m1    <= '0;
            r_bit_cnt   <= '0;
            r_reps_left <= '0;
            r_gap_cnt   <= '0;
            o_x         <= 1'b0;
            o_x_valid   <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort wins over a simultaneous start
                    if (i_start && !i_abort) begin
                        r_pat       <= w_aligned;
                        r_reps_left <= w_reps_eff;
                        if (w_len_eff == LEN_ZERO) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_state   <= S_SHIFT;
                            o_busy    <= 1'b1;
                            o_x_valid <= 1'b1;
                            o_x       <= w_aligned[MAX_LEN-1];
                            r_shift   <= w_aligned << 1;
                            r_len_m1  <= w_len_eff - LEN_ONE;
                            r_bit_cnt <= w_len_eff - LEN_ONE;
                        end
                    end
                end

                S_SHIFT: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        o_x       <= 1'b0;
                        o_x_valid <= 1'b0;
                        o_busy    <= 1'b0;
                    end else if (r_bit_cnt != LEN_ZERO) begin
                        o_x       <= r_shift[MAX_LEN-1];
                        r_shift   <= r_shift << 1;
                        r_bit_cnt <= r_bit_cnt - LEN_ONE;
                    end else if (r_reps_left > CNT_ONE) begin
                        r_reps_left <= r_reps_left - CNT_ONE;
                        if (GAP_CYCLES > 0) begin
                            r_state   <= S_GAP;
                            o_x       <= 1'b0;
                            o_x_valid <= 1'b0;
                            r_gap_cnt <= GAP_LAST;
                        end else begin
                            // back-to-back: first bit of the next repetition, no bubble
                            o_x       <= r_pat[MAX_LEN-1];
                            r_shift   <= r_pat << 1;
                            r_bit_cnt <= r_len_m1;
                        end
                    end else begin
                        r_state   <= S_DONE;
                        o_x       <= 1'b0;
                        o_x_valid <= 1'b0;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                    end
                end

                S_GAP: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        o_x       <= 1'b0;
                        o_x_valid <= 1'b0;
                        o_busy    <= 1'b0;
                    end else if (r_gap_cnt == '0) begin
                        r_state   <= S_SHIFT;
                        o_x_valid <= 1'b1;
                        o_x       <= r_pat[MAX_LEN-1];
                        r_shift   <= r_pat << 1;
                        r_bit_cnt <= r_len_m1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_ONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Bit-serial pattern transmitter: accepts a pattern word, a length and a repeat count over a valid/ready handshake, then drives the pattern MSB-first on a one-bit serial line, one bit per clock.
- Acts as the stimulus/transmit end for the team's serial sequence detectors.
- Optional idle gap between repetitions; one-cycle completion pulse; synchronous abort.

Parameters:
- MAX_LEN, 8, width of pattern port and maximum bits per repetition (2..16).
- LEN_W, 4, width of len port; must satisfy 2**LEN_W > MAX_LEN.
- CNT_W, 4, width of reps port.
- GAP_CYCLES, 0, idle cycles (x=0, x_valid=0) inserted between repetitions; 0 = back-to-back.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request valid.
- ready  output  1  high when a request can be accepted (IDLE only).
- pattern  input  MAX_LEN  pattern bits; bit len-1 sent first.
- len  input  LEN_W  bits per repetition.
- reps  input  CNT_W  repetition count.
- abort  input  1  synchronous cancel.
- x  output  1  serial data.
- x_valid  output  1  x carries a pattern bit this cycle.
- busy  output  1  transfer in progress (SHIFT or GAP).
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (async, rst=1): state=IDLE, x=0, x_valid=0, busy=0, done=0, ready=1, all counters/shift register cleared. Reset mid-transfer discards it; no done pulse.
- x, x_valid, done, busy are registered. ready is decoded from state (ready = state==IDLE).
- Handshake: accept on the rising edge where start=1 and ready=1. Latch pattern, effective length and effective reps. start while ready=0 is ignored, not queued.
- Effective length: len clamped to MAX_LEN if len>MAX_LEN.
- Effective reps: reps=0 is treated as 1.
- len=0: accept, emit no bits, go straight to DONE.

State machine:
- IDLE -> SHIFT on accept (len>0).
- IDLE -> DONE on accept (len=0).
- SHIFT: each cycle drives pattern bit (len-1-k) with x_valid=1.
- After the last bit of a repetition:
  - more reps remaining and GAP_CYCLES>0 -> GAP;
  - more reps remaining and GAP_CYCLES=0 -> reload, stay in SHIFT (no bubble);
  - last rep -> DONE.
- GAP: x=0, x_valid=0 for exactly GAP_CYCLES cycles, then SHIFT with the pattern reloaded.
- DONE: done=1, x_valid=0 for one cycle, then IDLE.

Latency and timing:
- Accept at edge N: first bit on x from edge N to N+1.
- Bits occupy len*reps cycles plus (reps-1)*GAP_CYCLES gap cycles.
- done is high in the cycle immediately after the last bit.
- ready returns to 1 the cycle after done.

Other rules:
- abort=1 in SHIFT/GAP: next edge -> IDLE, x=0, x_valid=0, no done. abort in IDLE/DONE has no effect. abort together with start in IDLE: abort wins, request not accepted.
- Outside SHIFT, x=0.
- Rep counter does not wrap: reps = 2**CNT_W-1 is sent exactly that many times.

Test Plan:
- Basic 1010 stream: GAP_CYCLES=0, pattern=8'h0A, len=4, reps=3 -> x = 1,0,1,0,1,0,1,0,1,0,1,0 over 12 consecutive cycles with x_valid=1; done one cycle later; ready=1 the following cycle.
- Gap insertion: GAP_CYCLES=2, pattern=8'h0B, len=4, reps=2 -> 1,0,1,1, then 2 cycles of x_valid=0, then 1,0,1,1, then done.
- Boundary lengths:
  - len=0, reps=5 -> no x_valid, done one cycle after accept.
  - len=12 (MAX_LEN=8), pattern=8'hA5, reps=0 -> 1,0,1,0,0,1,0,1 sent once, then done.
- Busy and abort:
  - start pulsed during SHIFT -> ignored; stream unchanged.
  - abort asserted on 3rd bit -> x_valid=0 next cycle, no done; ready=1.
- Reset mid-transfer: assert rst asynchronously between edges during SHIFT -> x=0, x_valid=0, ready=1 immediately; a new request after release transmits from its first bit.
